// File: rtl/ddr_disp_pkg.sv
// Shared constants for the multiplexed score display: glyphs, modes, converter states.
package ddr_disp_pkg;

  // Active-low segment glyphs, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic MODE_DEC = 1'b0;
  localparam logic MODE_HEX = 1'b1;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_e;

  // 4 * ceil(val_w * 0.302 + 1), in integer arithmetic
  function automatic int unsigned bcd_width(input int unsigned val_w);
    return 4 * ((val_w * 302 + 999) / 1000 + 1);
  endfunction

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
module bin2bcd_seq
  import ddr_disp_pkg::*;
#(
  parameter int unsigned VAL_W = 14,
  parameter int unsigned BCD_W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [VAL_W-1:0] i_bin,
  output logic             o_busy,
  output logic             o_done_c,
  output logic [BCD_W-1:0] o_bcd
);

  localparam int unsigned N_NIB = BCD_W / 4;
  localparam int unsigned CNT_W = $clog2(VAL_W + 1);

  conv_state_e      state_q, state_d;
  logic [VAL_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= CONV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    bcd_adj = bcd_q;

    // add-3 correction on every nibble before the shift
    for (int i = 0; i < N_NIB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    unique case (state_q)
      CONV_IDLE: begin
        if (i_start) begin
          state_d = CONV_SHIFT;
          bin_d   = i_bin;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CONV_SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[VAL_W-1]};
        bin_d = {bin_q[VAL_W-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VAL_W - 1)) begin
          state_d = CONV_DONE;
        end
      end
      CONV_DONE: begin
        busy_d  = 1'b0;
        state_d = CONV_IDLE;
      end
      default: state_d = CONV_IDLE;
    endcase
  end

  assign o_busy   = busy_q;
  assign o_done_c = (state_q == CONV_DONE);
  assign o_bcd    = bcd_q;

endmodule

// File: rtl/score_display_mux.sv
// Score/difficulty display: BCD or hex value, time-multiplexed onto N_DIGITS seven-segment digits.
module score_display_mux
  import ddr_disp_pkg::*;
#(
  parameter int unsigned VAL_W       = 14,
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [VAL_W-1:0]    i_value,
  input  logic                i_load,
  input  logic                i_mode,
  input  logic                i_blank_lz,
  input  logic                i_blink,
  input  logic [N_DIGITS-1:0] i_dp,
  output logic                o_busy,
  output logic                o_overflow,
  output logic [7:0]          o_seg,
  output logic [N_DIGITS-1:0] o_an
);

  localparam int unsigned BCD_W   = bcd_width(VAL_W);
  localparam int unsigned DISP_W  = 4 * N_DIGITS;
  localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned BCD_X_W = BCD_W + DISP_W;
  localparam int unsigned VAL_X_W = VAL_W + DISP_W;

  logic               conv_busy;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;

  logic [DISP_W-1:0]   disp_q, disp_d;
  logic                mode_q, mode_d;
  logic                ovf_q, ovf_d;
  logic [REF_W-1:0]    refresh_q, refresh_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic [BCD_X_W-1:0]  bcd_x;
  logic [VAL_X_W-1:0]  val_x;
  logic                dec_ovf, hex_ovf;
  logic [N_DIGITS-1:0] blank_vec;
  logic                zero_above;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                an_on;
  logic [6:0]          glyph;

  bin2bcd_seq #(
    .VAL_W (VAL_W),
    .BCD_W (BCD_W)
  ) u_bin2bcd (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_load && (i_mode == MODE_DEC)),
    .i_bin    (i_value),
    .o_busy   (conv_busy),
    .o_done_c (conv_done),
    .o_bcd    (conv_bcd)
  );

  // Overflow: anything left above the displayed nibbles
  assign bcd_x   = BCD_X_W'(conv_bcd);
  assign val_x   = VAL_X_W'(i_value);
  assign dec_ovf = |(bcd_x >> DISP_W);
  assign hex_ovf = |(val_x >> DISP_W);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      disp_q      <= '0;
      mode_q      <= MODE_DEC;
      ovf_q       <= 1'b0;
      refresh_q   <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      seg_q       <= '1;
      an_q        <= '1;
    end else begin
      disp_q      <= disp_d;
      mode_q      <= mode_d;
      ovf_q       <= ovf_d;
      refresh_q   <= refresh_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  always_comb begin
    disp_d      = disp_q;
    mode_d      = mode_q;
    ovf_d       = ovf_q;
    refresh_d   = refresh_q + REF_W'(1);
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q + BLK_W'(1);
    phase_d     = phase_q;
    seg_d       = '1;
    an_d        = '1;
    blank_vec   = '0;
    zero_above  = 1'b1;
    cur_nib     = '0;
    cur_dp      = 1'b0;
    cur_blank   = 1'b0;
    an_on       = 1'b0;
    glyph       = SEG_BLANK;

    // Display register, mode and overflow always move together
    if (conv_done) begin
      disp_d = DISP_W'(conv_bcd);
      mode_d = MODE_DEC;
      ovf_d  = dec_ovf;
    end else if (i_load && (i_mode == MODE_HEX) && !conv_busy) begin
      disp_d = DISP_W'(i_value);
      mode_d = MODE_HEX;
      ovf_d  = hex_ovf;
    end

    if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      idx_d     = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    // Leading zeros: scan from the most significant digit down
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_above   = zero_above && (disp_q[4*k +: 4] == 4'd0);
      blank_vec[k] = (k != 0) && zero_above && i_blank_lz && !ovf_q;
    end

    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = disp_q[4*k +: 4];
        cur_dp    = i_dp[k];
        cur_blank = blank_vec[k];
      end
    end

    glyph = ((mode_q == MODE_DEC) && (cur_nib > 4'd9)) ? SEG_BLANK : hex_glyph(cur_nib);
    an_on = !cur_blank && !(i_blink && phase_q);

    if (!cur_blank) begin
      seg_d = {~cur_dp, (ovf_q ? SEG_DASH : glyph)};
    end

    for (int k = 0; k < N_DIGITS; k++) begin
      if ((idx_q == IDX_W'(k)) && an_on) begin
        an_d[k] = 1'b0;
      end
    end
  end

  assign o_busy     = conv_busy;
  assign o_overflow = ovf_q;
  assign o_seg      = seg_q;
  assign o_an       = an_q;

endmodule

// File: tb/tb_score_display_mux.sv
// Self-checking bench for score_display_mux: vector table plus scan scoreboard and corner sequences.
`timescale 1ns/1ps
module tb_score_display_mux;

  localparam int unsigned VAL_W       = 14;
  localparam int unsigned N_DIGITS    = 4;
  localparam int unsigned REFRESH_DIV = 4;
  localparam int unsigned BLINK_DIV   = 64;
  localparam int          N_VEC       = 10;

  logic                i_clk = 1'b0;
  logic                i_rst = 1'b1;
  logic [VAL_W-1:0]    i_value = '0;
  logic                i_load = 1'b0;
  logic                i_mode = 1'b0;
  logic                i_blank_lz = 1'b0;
  logic                i_blink = 1'b0;
  logic [N_DIGITS-1:0] i_dp = '0;
  logic                o_busy;
  logic                o_overflow;
  logic [7:0]          o_seg;
  logic [N_DIGITS-1:0] o_an;

  score_display_mux #(
    .VAL_W       (VAL_W),
    .N_DIGITS    (N_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_value    (i_value),
    .i_load     (i_load),
    .i_mode     (i_mode),
    .i_blank_lz (i_blank_lz),
    .i_blink    (i_blink),
    .i_dp       (i_dp),
    .o_busy     (o_busy),
    .o_overflow (o_overflow),
    .o_seg      (o_seg),
    .o_an       (o_an)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
  } slot_t;

  typedef struct packed {
    logic [13:0] val;
    logic        mode;
    logic        blz;
    logic [3:0]  dp;
    logic        ovf;
    logic [3:0]  lit;   // which digits drive their anode
    logic [31:0] segs;  // digit k expected seg in [8k +: 8]
  } vec_t;

  slot_t exp_q[$];
  vec_t  vecs[N_VEC];
  int    n_pass  = 0;
  int    n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_load(input logic [13:0] v, input logic m);
    i_value = v;
    i_mode  = m;
    i_load  = 1'b1;
    @(negedge i_clk);
    i_load  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (o_busy === 1'b1 && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 40) check({name, "_idle_timeout"}, 32'(o_busy), 32'd0);
  endtask

  task automatic push_expect(input logic [3:0] lit, input logic [31:0] segs);
    slot_t s;
    for (int k = 0; k < 4; k++) begin
      s.an  = lit[k] ? ~(4'b0001 << k) : 4'hF;
      s.seg = segs[8*k +: 8];
      exp_q.push_back(s);
    end
  endtask

  // Align to the first cycle of a digit-0 slot, then pop one record per slot
  task automatic scan_check(input string name);
    int    n;
    slot_t e;
    n = 0;
    while (o_an === 4'b1110 && n < 64) begin
      @(negedge i_clk);
      n++;
    end
    while (o_an !== 4'b1110 && n < 64) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 64) begin
      n_total++;
      $display("FAIL %s_sync: no digit-0 slot within 64 cycles, an=%b", name, o_an);
      exp_q.delete();
    end else begin
      for (int k = 0; k < 4; k++) begin
        e = exp_q.pop_front();
        check($sformatf("%s_an%0d", name, k), 32'(o_an), 32'(e.an));
        check($sformatf("%s_seg%0d", name, k), 32'(o_seg), 32'(e.seg));
        repeat (REFRESH_DIV) @(negedge i_clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int dark_cnt;

    //           val        mode  blz   dp       ovf   lit      segs d3..d0
    vecs[0] = '{14'd1234,  1'b0, 1'b0, 4'b0000, 1'b0, 4'b1111, 32'hF9A4B099};
    vecs[1] = '{14'd7,     1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 32'hFFFFFFF8};
    vecs[2] = '{14'd10000, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b1111, 32'hBFBFBFBF};
    vecs[3] = '{14'd42,    1'b0, 1'b0, 4'b0000, 1'b0, 4'b1111, 32'hC0C099A4};
    vecs[4] = '{14'h02AF,  1'b1, 1'b0, 4'b0001, 1'b0, 4'b1111, 32'hC0A4880E};
    vecs[5] = '{14'd9999,  1'b0, 1'b0, 4'b0000, 1'b0, 4'b1111, 32'h90909090};
    vecs[6] = '{14'd1050,  1'b0, 1'b1, 4'b1010, 1'b0, 4'b1111, 32'h79C012C0};
    vecs[7] = '{14'd12345, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b1111, 32'hBFBFBFBF};
    vecs[8] = '{14'd0,     1'b0, 1'b1, 4'b1111, 1'b0, 4'b0001, 32'hFFFFFF40};
    vecs[9] = '{14'h000A,  1'b1, 1'b1, 4'b0000, 1'b0, 4'b0001, 32'hFFFFFF88};

    // Reset
    #1 i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_an",   32'(o_an), 32'hF);
    check("rst_seg",  32'(o_seg), 32'hFF);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ovf",  32'(o_overflow), 32'd0);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("post_rst_an",  32'(o_an), 32'hE);
    check("post_rst_seg", 32'(o_seg), 32'hC0);

    // Table-driven loads
    for (int i = 0; i < N_VEC; i++) begin
      i_blank_lz = vecs[i].blz;
      i_dp       = vecs[i].dp;
      push_expect(vecs[i].lit, vecs[i].segs);
      do_load(vecs[i].val, vecs[i].mode);
      check($sformatf("v%0d_busy", i), 32'(o_busy), 32'(vecs[i].mode == 1'b0));
      wait_idle($sformatf("v%0d", i));
      check($sformatf("v%0d_ovf", i), 32'(o_overflow), 32'(vecs[i].ovf));
      scan_check($sformatf("v%0d", i));
    end

    // Decimal latency: busy for 15 cycles, overflow lands on cycle 16
    i_blank_lz = 1'b0;
    i_dp       = '0;
    do_load(14'd10000, 1'b0);
    busy_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (o_busy === 1'b1) busy_cnt++;
      if (c == 15) check("ovf_cycle15", 32'(o_overflow), 32'd0);
      if (c == 16) check("ovf_cycle16", 32'(o_overflow), 32'd1);
      @(negedge i_clk);
    end
    check("busy_len", 32'(busy_cnt), 32'd15);

    // Loads during conversion are dropped
    push_expect(4'b1111, 32'hF9A4B099);
    do_load(14'd1234, 1'b0);
    @(negedge i_clk);
    do_load(14'd5678, 1'b0);
    @(negedge i_clk);
    do_load(14'h02AF, 1'b1);
    wait_idle("ignore");
    check("ignore_ovf_clear", 32'(o_overflow), 32'd0);
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_busy === 1'b1) busy_cnt++;
      @(negedge i_clk);
    end
    check("ignore_no_requeue", 32'(busy_cnt), 32'd0);
    scan_check("ignore");

    // Reset mid-conversion drops busy without a clock edge
    do_load(14'd1234, 1'b0);
    repeat (4) @(negedge i_clk);
    check("midrst_busy_before", 32'(o_busy), 32'd1);
    #2 i_rst = 1'b0;
    #1;
    check("midrst_busy_async", 32'(o_busy), 32'd0);
    check("midrst_an",         32'(o_an), 32'hF);
    check("midrst_seg",        32'(o_seg), 32'hFF);
    @(negedge i_clk);
    i_rst = 1'b1;
    push_expect(4'b1111, 32'hC0C0C0C0);
    scan_check("midrst");
    check("midrst_busy_after", 32'(o_busy), 32'd0);

    // Blink: anodes dark for half of each 128-cycle period
    i_blink  = 1'b1;
    dark_cnt = 0;
    for (int c = 0; c < 256; c++) begin
      if (o_an === 4'hF) dark_cnt++;
      @(negedge i_clk);
    end
    check("blink_dark", 32'(dark_cnt), 32'd128);
    i_blink  = 1'b0;
    repeat (2) @(negedge i_clk);
    dark_cnt = 0;
    for (int c = 0; c < 256; c++) begin
      if (o_an === 4'hF) dark_cnt++;
      @(negedge i_clk);
    end
    check("blink_off_dark", 32'(dark_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
